// File: rtl/bsg_manycore_dram_xlate_pkg.sv
// Shared types for the DRAM translation arbiter: FIFO entry layout, count encoding
// and a safe clog2 helper.
package bsg_manycore_dram_xlate_pkg;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int num_req_lp      = 4;
   localparam int epa_width_lp    = 28;
   localparam int x_width_lp      = 7;
   localparam int y_width_lp      = 7;
   localparam int req_id_width_lp = safe_clog2(num_req_lp);

   typedef enum logic [1:0] {
      fifo_empty_e = 2'd0,
      fifo_one_e   = 2'd1,
      fifo_full_e  = 2'd2
   } fifo_count_e;

   typedef struct packed {
      logic [req_id_width_lp-1:0] req_id;
      logic [epa_width_lp-1:0]    epa;
      logic [x_width_lp-1:0]      x_cord;
      logic [y_width_lp-1:0]      y_cord;
   } fifo_entry_s;

endpackage

// File: rtl/bsg_manycore_dram_xlate_arbiter_chk.sv
// Protocol checker: the consumer may only dequeue a valid head.
module bsg_manycore_dram_xlate_arbiter_chk (
   input logic clk_i,
   input logic reset_i,
   input logic yumi_i,
   input logic head_v
);

   yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) (yumi_i |-> head_v));

endmodule

// File: rtl/bsg_manycore_dram_xlate_rr_arb.sv
// Rotating-priority one-hot arbiter with pointer update.
// BSG_DRAM_XLATE_ARB_FIXED_PRIO_EN selects lowest-index-wins instead.
module bsg_manycore_dram_xlate_rr_arb
   import bsg_manycore_dram_xlate_pkg::*;
#(
   parameter int num_req_p = 4,
   localparam int id_width_lp = safe_clog2(num_req_p)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [num_req_p-1:0]   v_i,
   output logic [num_req_p-1:0]   grant_o,
   output logic [id_width_lp-1:0] grant_id_o,
   output logic                   grant_v_o
);

`ifdef BSG_DRAM_XLATE_ARB_FIXED_PRIO_EN
   logic unused_s;
   assign unused_s = clk_i ^ reset_i;

   always_comb begin
      grant_o    = '0;
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
         if (!grant_v_o && v_i[i]) begin
            grant_o[i] = 1'b1;
            grant_id_o = id_width_lp'(i);
            grant_v_o  = 1'b1;
         end else begin
            grant_v_o  = grant_v_o;
         end
      end
   end
`else
   logic [id_width_lp-1:0] ptr_r;
   int                     idx_s;

   // first valid requester at or after the pointer, wrapping
   always_comb begin
      grant_o    = '0;
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      idx_s      = 0;
      for (int i = 0; i < num_req_p; i++) begin
         idx_s = (int'(ptr_r) + i) % num_req_p;
         if (!grant_v_o && v_i[idx_s]) begin
            grant_o[idx_s] = 1'b1;
            grant_id_o     = id_width_lp'(idx_s);
            grant_v_o      = 1'b1;
         end else begin
            grant_v_o      = grant_v_o;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (grant_v_o)
         ptr_r <= (grant_id_o == id_width_lp'(num_req_p - 1)) ? '0 : grant_id_o + id_width_lp'(1);
      else
         ptr_r <= ptr_r;
   end
`endif

endmodule

// File: rtl/bsg_manycore_dram_xlate_arbiter.sv
// Shares one DRAM hash unit among requesters; results queue in a 2-entry FIFO.
// Define BSG_DRAM_XLATE_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module bsg_manycore_dram_xlate_arbiter
   import bsg_manycore_dram_xlate_pkg::*;
#(
   parameter int num_req_p      = num_req_lp,
   parameter int data_width_p   = 32,
   parameter int addr_width_p   = epa_width_lp,
   parameter int x_cord_width_p = x_width_lp,
   parameter int y_cord_width_p = y_width_lp,
   localparam int req_id_width_lp = safe_clog2(num_req_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_req_p-1:0]              v_i,
   input  logic [num_req_p*data_width_p-1:0] eva_i,
   output logic [num_req_p-1:0]              ready_o,
   output logic [data_width_p-1:0]           hash_eva_o,
   input  logic [addr_width_p-1:0]           hash_epa_i,
   input  logic [x_cord_width_p-1:0]         hash_x_cord_i,
   input  logic [y_cord_width_p-1:0]         hash_y_cord_i,
   output logic                              v_o,
   output logic [addr_width_p-1:0]           epa_o,
   output logic [x_cord_width_p-1:0]         x_cord_o,
   output logic [y_cord_width_p-1:0]         y_cord_o,
   output logic [req_id_width_lp-1:0]        req_id_o,
   input  logic                              yumi_i
);

   fifo_count_e                 count_r, count_n;
   fifo_entry_s                 mem_r [2];
   fifo_entry_s                 wr_entry_s, head_entry_s;
   logic                        head_r, tail_r;
   logic                        can_accept_s, enq_s, deq_s;
   logic [num_req_p-1:0]        req_v_s;
   logic [req_id_width_lp-1:0]  grant_id_s;

   // no grant into a full FIFO or during reset; yumi never frees a slot this cycle
   assign can_accept_s = (count_r != fifo_full_e) && !reset_i;
   assign req_v_s      = can_accept_s ? v_i : '0;
   assign v_o          = (count_r != fifo_empty_e);
   assign deq_s        = yumi_i && v_o;

   bsg_manycore_dram_xlate_rr_arb #(.num_req_p(num_req_p)) arb (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .v_i        (req_v_s),
      .grant_o    (ready_o),
      .grant_id_o (grant_id_s),
      .grant_v_o  (enq_s)
   );

   always_comb begin
      hash_eva_o = '0;
      if (enq_s)
         hash_eva_o = eva_i[grant_id_s*data_width_p +: data_width_p];
      else
         hash_eva_o = '0;
   end

   assign wr_entry_s = '{req_id: grant_id_s, epa: hash_epa_i,
                         x_cord: hash_x_cord_i, y_cord: hash_y_cord_i};

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_r <= fifo_empty_e;
      else
         count_r <= count_n;
   end

   always_comb begin
      count_n = count_r;
      case (count_r)
         fifo_empty_e: count_n = enq_s ? fifo_one_e : fifo_empty_e;
         fifo_one_e: begin
            if (enq_s && !deq_s)
               count_n = fifo_full_e;
            else if (!enq_s && deq_s)
               count_n = fifo_empty_e;
            else
               count_n = fifo_one_e;
         end
         fifo_full_e:  count_n = deq_s ? fifo_one_e : fifo_full_e;
         default:      count_n = fifo_empty_e;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mem_r[0] <= '0;
         mem_r[1] <= '0;
         head_r   <= 1'b0;
         tail_r   <= 1'b0;
      end else begin
         if (enq_s) begin
            mem_r[tail_r] <= wr_entry_s;
            tail_r        <= ~tail_r;
         end
         if (deq_s)
            head_r <= ~head_r;
      end
   end

   assign head_entry_s = mem_r[head_r];
   assign epa_o        = v_o ? head_entry_s.epa    : '0;
   assign x_cord_o     = v_o ? head_entry_s.x_cord : '0;
   assign y_cord_o     = v_o ? head_entry_s.y_cord : '0;
   assign req_id_o     = v_o ? head_entry_s.req_id : '0;

   bsg_manycore_dram_xlate_arbiter_chk chk (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .yumi_i  (yumi_i),
      .head_v  (v_o)
   );

endmodule

// File: tb/tb_bsg_manycore_dram_xlate_arbiter.sv
// Directed bench for bsg_manycore_dram_xlate_arbiter with a behavioural hash unit.
module tb_bsg_manycore_dram_xlate_arbiter;

   logic         clk = 1'b0;
   logic         reset_i;
   logic [3:0]   v_i;
   logic [127:0] eva_i;
   logic [3:0]   ready_o;
   logic [31:0]  hash_eva_o;
   logic [27:0]  hash_epa_i;
   logic [6:0]   hash_x_cord_i, hash_y_cord_i;
   logic         v_o;
   logic [27:0]  epa_o;
   logic [6:0]   x_cord_o, y_cord_o;
   logic [1:0]   req_id_o;
   logic         yumi_i;
   logic [31:0]  eva_tab [4];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   function automatic logic [27:0] m_epa(input logic [31:0] e);
      return {4'h0, e[27:4]};
   endfunction
   function automatic logic [6:0] m_x(input logic [31:0] e);
      return e[6:0] ^ 7'h52;
   endfunction
   function automatic logic [6:0] m_y(input logic [31:0] e);
      return e[13:7] ^ 7'h29;
   endfunction

   assign hash_epa_i    = m_epa(hash_eva_o);
   assign hash_x_cord_i = m_x(hash_eva_o);
   assign hash_y_cord_i = m_y(hash_eva_o);

   always_comb begin
      for (int k = 0; k < 4; k++) eva_i[k*32 +: 32] = eva_tab[k];
   end

   bsg_manycore_dram_xlate_arbiter dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .eva_i(eva_i), .ready_o(ready_o),
      .hash_eva_o(hash_eva_o), .hash_epa_i(hash_epa_i), .hash_x_cord_i(hash_x_cord_i),
      .hash_y_cord_i(hash_y_cord_i), .v_o(v_o), .epa_o(epa_o), .x_cord_o(x_cord_o),
      .y_cord_o(y_cord_o), .req_id_o(req_id_o), .yumi_i(yumi_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      eva_tab[0] = 32'hA000_0100;
      eva_tab[1] = 32'hA000_0210;
      eva_tab[2] = 32'hA000_0320;
      eva_tab[3] = 32'hA000_0430;
      reset_i = 1'b1;
      v_i     = 4'hF;
      yumi_i  = 1'b0;
      tick();
      #1;
      chk("rst_ready",  64'(ready_o),  64'h0);
      chk("rst_v",      64'(v_o),      64'h0);
      chk("rst_epa",    64'(epa_o),    64'h0);
      chk("rst_req_id", 64'(req_id_o), 64'h0);
      reset_i = 1'b0;

`ifndef BSG_DRAM_XLATE_ARB_FIXED_PRIO_EN
      // round robin with continuous drain
      for (int c = 0; c < 6; c++) begin
         yumi_i = v_o;
         #1;
         chk("rr_ready", 64'(ready_o), 64'(4'b0001 << (c % 4)));
         if (c >= 1) begin
            chk("rr_v",      64'(v_o),      64'h1);
            chk("rr_req_id", 64'(req_id_o), 64'((c - 1) % 4));
            chk("rr_epa",    64'(epa_o),    64'(m_epa(eva_tab[(c - 1) % 4])));
         end
         tick();
      end
      v_i    = 4'h0;
      yumi_i = 1'b1;
      #1;
      chk("drain_v", 64'(v_o), 64'h1);
      tick();
      yumi_i = 1'b0;

      // single request through the hash unit
      eva_tab[2] = 32'h8000_1040;
      v_i = 4'b0100;
      #1;
      chk("one_ready", 64'(ready_o),    64'h4);
      chk("one_eva",   64'(hash_eva_o), 64'h8000_1040);
      tick();
      v_i = 4'h0;
      #1;
      chk("one_v",      64'(v_o),      64'h1);
      chk("one_epa",    64'(epa_o),    64'h000_0104);
      chk("one_x",      64'(x_cord_o), 64'h12);
      chk("one_y",      64'(y_cord_o), 64'h09);
      chk("one_req_id", 64'(req_id_o), 64'h2);
      chk("one_idle",   64'(ready_o),  64'h0);
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      #1;
      chk("empty_v",   64'(v_o),      64'h0);
      chk("empty_epa", 64'(epa_o),    64'h0);
      chk("empty_x",   64'(x_cord_o), 64'h0);

      // fill to FULL, no yumi bypass
      v_i = 4'hF;
      #1;
      chk("fill_g3", 64'(ready_o), 64'h8);
      tick();
      #1;
      chk("fill_g0",  64'(ready_o),  64'h1);
      chk("fill_id3", 64'(req_id_o), 64'h3);
      tick();
      #1;
      chk("full_ready", 64'(ready_o),    64'h0);
      chk("full_eva",   64'(hash_eva_o), 64'h0);
      tick();
      #1;
      chk("full_hold", 64'(ready_o), 64'h0);
      yumi_i = 1'b1;
      #1;
      chk("full_yumi_ready", 64'(ready_o), 64'h0);
      tick();
      yumi_i = 1'b0;
      #1;
      chk("after_yumi_g1", 64'(ready_o),  64'h2);
      chk("after_yumi_id", 64'(req_id_o), 64'h0);
      tick();

      // reset while FULL
      reset_i = 1'b1;
      #1;
      chk("rst_full_ready", 64'(ready_o), 64'h0);
      tick();
      #1;
      chk("rst_full_v",  64'(v_o),     64'h0);
      chk("rst_full_rd", 64'(ready_o), 64'h0);
      reset_i = 1'b0;
      #1;
      chk("post_rst_g0", 64'(ready_o), 64'h1);
      tick();

      // enqueue and dequeue together while ONE
      v_i    = 4'b0100;
      yumi_i = 1'b1;
      #1;
      chk("sim_v",     64'(v_o),      64'h1);
      chk("sim_head",  64'(req_id_o), 64'h0);
      chk("sim_epa",   64'(epa_o),    64'(m_epa(eva_tab[0])));
      chk("sim_ready", 64'(ready_o),  64'h4);
      tick();
      v_i = 4'h0;
      #1;
      chk("sim_v_hold", 64'(v_o),      64'h1);
      chk("sim_next",   64'(req_id_o), 64'h2);
      chk("sim_next_y", 64'(y_cord_o), 64'(m_y(eva_tab[2])));
      tick();
      yumi_i = 1'b0;
      #1;
      chk("sim_drained", 64'(v_o), 64'h0);
`else
      // fixed priority: lowest valid index always wins
      v_i = 4'b1010;
      for (int c = 0; c < 6; c++) begin
         yumi_i = v_o;
         #1;
         chk("fp_ready", 64'(ready_o), 64'h2);
         if (c >= 1) begin
            chk("fp_req_id", 64'(req_id_o), 64'h1);
            chk("fp_x",      64'(x_cord_o), 64'(m_x(eva_tab[1])));
         end
         tick();
      end
      v_i    = 4'h0;
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      #1;
      chk("fp_drained", 64'(v_o), 64'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
